// File: rtl/add_arb_pkg.sv
// Shared types and constants for the two-requester arbitrated adder.
package add_arb_pkg;

    localparam int unsigned AddArbWidth = 32;

    // The state bit doubles as rvalid.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } arb_state_e;

    localparam logic ReqIdx0 = 1'b0;
    localparam logic ReqIdx1 = 1'b1;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/add_arb_if.sv
// Request/result bundle for add_arb; ovf exists only when ADD_ARB_OVF_EN is defined.
interface add_arb_if #(
    parameter int unsigned WIDTH = add_arb_pkg::AddArbWidth
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ci0;
    logic             ci1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             rvalid;
    logic             rid;
    logic             rack;
`ifdef ADD_ARB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output req0, req1, a0, b0, a1, b1, ci0, ci1, rack,
        input  gnt0, gnt1, s, co, rvalid, rid
`ifdef ADD_ARB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, ci0, ci1, rack,
        output gnt0, gnt1, s, co, rvalid, rid
`ifdef ADD_ARB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/add_reg.sv
// Registered ripple-carry adder, loaded when en is high; optional ovf under ADD_ARB_OVF_EN.
module add_reg
    import add_arb_pkg::*;
#(
    parameter int unsigned WIDTH = AddArbWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef ADD_ARB_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = ci;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else if (en) begin
            s_q  <= sum;
            co_q <= carry[WIDTH];
        end
    end

    assign s  = s_q;
    assign co = co_q;

`ifdef ADD_ARB_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: rtl/add_arb.sv
// Two-requester round-robin arbiter feeding one registered adder with a single result slot.
// Optional signed-overflow output enabled by ADD_ARB_OVF_EN.
module add_arb
    import add_arb_pkg::*;
#(
    parameter int unsigned WIDTH = AddArbWidth
) (
    input logic       clk,
    input logic       rst,
    add_arb_if.slave  bus
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             prio_q;
    logic             prio_d;
    logic             rid_q;
    logic             slot_free;
    logic             gnt0;
    logic             gnt1;
    logic             grant;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             ci_sel;

    // A full slot may be reissued in the same cycle it is acknowledged.
    assign slot_free = (state_q == StEmpty) || bus.rack;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (!rst && slot_free) begin
            gnt0 = bus.req0 && (!bus.req1 || (prio_q == ReqIdx0));
            gnt1 = bus.req1 && (!bus.req0 || (prio_q == ReqIdx1));
        end
        grant = gnt0 || gnt1;
        if (grant) begin
            state_d = StFull;
            prio_d  = other_req(gnt1 ? ReqIdx1 : ReqIdx0);
        end else if ((state_q == StFull) && bus.rack) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            prio_q  <= ReqIdx0;
            rid_q   <= ReqIdx0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (grant) begin
                rid_q <= gnt1 ? ReqIdx1 : ReqIdx0;
            end
        end
    end

    always_comb begin
        a_sel  = gnt1 ? bus.a1  : bus.a0;
        b_sel  = gnt1 ? bus.b1  : bus.b0;
        ci_sel = gnt1 ? bus.ci1 : bus.ci0;
    end

    add_reg #(
        .WIDTH (WIDTH)
    ) u_add_reg (
        .clk (clk),
        .rst (rst),
        .a   (a_sel),
        .b   (b_sel),
        .ci  (ci_sel),
        .en  (grant),
        .s   (bus.s),
        .co  (bus.co)
`ifdef ADD_ARB_OVF_EN
        ,
        .ovf (bus.ovf)
`endif
    );

    assign bus.gnt0   = gnt0;
    assign bus.gnt1   = gnt1;
    assign bus.rvalid = (state_q == StFull);
    assign bus.rid    = rid_q;

endmodule

// File: tb/tb_add_arb.sv
// Directed bench for add_arb: expected results are queued at grant time and checked next cycle.
module tb_add_arb;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         rid;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];
    res_t last;

    add_arb_if #(.WIDTH(W)) bus ();

    add_arb #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic rid);
        res_t       r;
        logic [W:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.s   = full[W-1:0];
        r.co  = full[W];
        r.rid = rid;
        r.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(input logic eg0, input logic eg1, input logic erv);
        bit pushed;
        pushed = 0;
        #1;
        chk("gnt0", {63'd0, bus.gnt0}, {63'd0, eg0});
        chk("gnt1", {63'd0, bus.gnt1}, {63'd0, eg1});
        if (eg0) begin
            sb.push_back(model(bus.a0, bus.b0, bus.ci0, 1'b0));
            pushed = 1;
        end else if (eg1) begin
            sb.push_back(model(bus.a1, bus.b1, bus.ci1, 1'b1));
            pushed = 1;
        end
        @(posedge clk);
        #1;
        if (pushed) last = sb.pop_front();
        chk("rvalid", {63'd0, bus.rvalid}, {63'd0, erv});
        chk("s", {32'd0, bus.s}, {32'd0, last.s});
        chk("co", {63'd0, bus.co}, {63'd0, last.co});
        chk("rid", {63'd0, bus.rid}, {63'd0, last.rid});
`ifdef ADD_ARB_OVF_EN
        chk("ovf", {63'd0, bus.ovf}, {63'd0, last.ovf});
`endif
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        bus.ci0  = 1'b0;
        bus.ci1  = 1'b0;
        bus.rack = 1'b0;
        last     = '0;
        @(negedge clk);

        // Reset: no grants even with both requesting.
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Single requester 0.
        rst      = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = 32'h0001_000F;
        bus.b0   = 32'h0000_0001;
        tick(1'b1, 1'b0, 1'b1);
        chk("s031", {32'd0, last.s}, 64'h0001_0010);

        // Acknowledge with no request: slot empties, data held.
        bus.req0 = 1'b0;
        bus.rack = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // Single requester 1 with wrap-around.
        bus.req1 = 1'b1;
        bus.a1   = 32'hFFFF_FFFF;
        bus.b1   = 32'h0000_0001;
        bus.ci1  = 1'b1;
        tick(1'b0, 1'b1, 1'b1);

        // Reset then both requesting: strict alternation starting at 0.
        bus.req0 = 1'b1;
        rst      = 1'b1;
        last     = '0;
        tick(1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        bus.a0   = 32'hFFFF_0000;
        bus.b0   = 32'h0000_FFFF;
        bus.a1   = 32'h0814_D1A0;
        bus.b1   = 32'h1220_7E0A;
        bus.ci1  = 1'b0;
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("s033", {32'd0, last.s}, 64'h1A35_4FAA);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);

        // Back-pressure: result held, operand changes ignored.
        bus.req1 = 1'b0;
        bus.rack = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        bus.a0   = 32'h1234_5678;
        bus.b0   = 32'h1111_1111;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        bus.rack = 1'b1;
        tick(1'b1, 1'b0, 1'b1);

        // Reset while full with both requesting.
        bus.req1 = 1'b1;
        rst      = 1'b1;
        last     = '0;
        tick(1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        tick(1'b1, 1'b0, 1'b1);

        // Signed overflow case.
        bus.req1 = 1'b0;
        bus.a0   = 32'h7FFF_FFFF;
        bus.b0   = 32'h0000_0001;
        tick(1'b1, 1'b0, 1'b1);
        chk("s036", {32'd0, last.s}, 64'h8000_0000);

        bus.req0 = 1'b0;
        tick(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
